// File: rtl/sys_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sys_pkg : shared gather-FSM encoding and width helpers for sys_skewer       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package sys_pkg;

    typedef logic [0:0] gstate_t;

    localparam gstate_t G_IDLE = 1'b0;
    localparam gstate_t G_FILL = 1'b1;

    function automatic int calc_chunk_w(input int num_inputs, input int depth_in);
        return num_inputs / depth_in;
    endfunction

    // One spare bit so the counter can hold DepthIn-1 for any DepthIn, including 1.
    function automatic int calc_cnt_w(input int depth_in);
        return $clog2(depth_in) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_delay_line.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sys_delay_line : Depth-stage data+valid shift register, async active-low clr|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sys_delay_line #(
    parameter int BitSize = 8,
    parameter int Depth   = 1
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               in_valid,
    input  logic [BitSize-1:0] in_data,
    output logic               out_valid,
    output logic [BitSize-1:0] out_data,
    output logic               out_valid_nxt
);

    logic [Depth-1:0]              valid_q, valid_d;
    logic [Depth-1:0][BitSize-1:0] data_q, data_d;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < Depth; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid     = valid_q[Depth-1];
    assign out_data      = data_q[Depth-1];
    // Lets the parent see next cycle's lane activity for the drain pulse.
    assign out_valid_nxt = valid_d[Depth-1];

endmodule
`default_nettype wire

// File: rtl/sys_skewer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sys_skewer : gathers DepthIn stacked chunks into a row, re-emits it skewed  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sys_skewer
    import sys_pkg::*;
#(
    parameter int BitSize     = 8,
    parameter int NumOfInputs = 4,
    parameter int DepthIn     = 2,
    localparam int ChunkW     = calc_chunk_w(NumOfInputs, DepthIn)
) (
    input  logic                                  clk,
    input  logic                                  res_n,
    input  logic                                  in_valid,
    input  logic                                  in_start,
    input  logic [ChunkW-1:0][BitSize-1:0]        in_data,
    output logic                                  out_valid,
    output logic                                  out_start,
    output logic                                  out_done,
    output logic [NumOfInputs-1:0][BitSize-1:0]   out_data
);

    localparam int CntW = calc_cnt_w(DepthIn);

    if (NumOfInputs % DepthIn != 0) begin : g_bad_depth
        $error("sys_skewer: NumOfInputs must be a multiple of DepthIn");
    end

    gstate_t                               state_q, state_d;
    logic [CntW-1:0]                       cnt_q, cnt_d;
    logic [NumOfInputs-1:0][BitSize-1:0]   gather_q, gather_d;
    logic [NumOfInputs-1:0][BitSize-1:0]   issue_data_q, issue_data_d;
    logic                                  issue_valid_q, issue_valid_d;
    logic                                  done_q, done_d;
    logic                                  wr_en;
    logic [CntW-1:0]                       wr_idx;

    logic [NumOfInputs-1:0]                lane_valid, lane_valid_nxt;
    logic [NumOfInputs-1:0][BitSize-1:0]   lane_data;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gather_d      = gather_q;
        issue_data_d  = issue_data_q;
        issue_valid_d = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = '0;

        // A start always resyncs to chunk 0; a non-start chunk only counts mid-row.
        if (in_valid) begin
            if (in_start) begin
                wr_en  = 1'b1;
                wr_idx = '0;
                if (DepthIn == 1) begin
                    issue_valid_d = 1'b1;
                    state_d       = G_IDLE;
                    cnt_d         = '0;
                end else begin
                    state_d = G_FILL;
                    cnt_d   = CntW'(1);
                end
            end else if (state_q == G_FILL) begin
                wr_en  = 1'b1;
                wr_idx = cnt_q;
                if (cnt_q == CntW'(DepthIn - 1)) begin
                    issue_valid_d = 1'b1;
                    state_d       = G_IDLE;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end

        if (wr_en) begin
            for (int c = 0; c < DepthIn; c++) begin
                if (wr_idx == CntW'(c)) begin
                    for (int j = 0; j < ChunkW; j++) begin
                        gather_d[c*ChunkW + j] = in_data[j];
                    end
                end
            end
        end

        // The completing chunk is forwarded straight into the issue register.
        if (issue_valid_d) begin
            issue_data_d = gather_d;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q       <= G_IDLE;
            cnt_q         <= '0;
            gather_q      <= '0;
            issue_data_q  <= '0;
            issue_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gather_q      <= gather_d;
            issue_data_q  <= issue_data_d;
            issue_valid_q <= issue_valid_d;
            done_q        <= done_d;
        end
    end

    assign lane_valid[0]     = issue_valid_q;
    assign lane_valid_nxt[0] = issue_valid_d;
    assign lane_data[0]      = issue_data_q[0];

    for (genvar k = 1; k < NumOfInputs; k++) begin : g_lane
        sys_delay_line #(
            .BitSize (BitSize),
            .Depth   (k)
        ) u_delay (
            .clk           (clk),
            .res_n         (res_n),
            .in_valid      (issue_valid_q),
            .in_data       (issue_data_q[k]),
            .out_valid     (lane_valid[k]),
            .out_data      (lane_data[k]),
            .out_valid_nxt (lane_valid_nxt[k])
        );
    end

    // Idle lanes must read as zero: downstream accumulates across lanes.
    always_comb begin
        for (int k = 0; k < NumOfInputs; k++) begin
            out_data[k] = lane_valid[k] ? lane_data[k] : '0;
        end
    end

    assign out_valid = |lane_valid;
    assign out_start = issue_valid_q;
    assign done_d    = out_valid & ~(|lane_valid_nxt);
    assign out_done  = done_q;

endmodule
`default_nettype wire
